// File: rtl/add_seq_ctrl_pkg.sv
// Shared definitions for the nibble-serial add/subtract controller.
package add_seq_ctrl_pkg;

    localparam int NIBBLE_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Ceiling log2. The nibble index width is clog2(NIBBLES), at least 1 bit.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

endpackage

// File: rtl/add_seq_ctrl_add4.sv
// 4-bit ripple adder slice with carry-in, built from 1-bit full-adder cells.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);
    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));
endmodule

module add4_ci
    import add_seq_ctrl_pkg::*;
(
    input  logic [NIBBLE_W-1:0] a,
    input  logic [NIBBLE_W-1:0] b,
    input  logic                ci,
    output logic [NIBBLE_W-1:0] s,
    output logic                co
);
    logic [NIBBLE_W:0] c;

    assign c[0] = ci;
    assign co   = c[NIBBLE_W];

    for (genvar i = 0; i < NIBBLE_W; i++) begin : g_bit
        full_adder u_fa (
            .a  (a[i]),
            .b  (b[i]),
            .ci (c[i]),
            .s  (s[i]),
            .co (c[i+1])
        );
    end
endmodule

// File: rtl/add_seq_ctrl.sv
// Sequences one shared 4-bit adder slice over NIBBLES cycles to form a
// 4*NIBBLES-bit sum or difference, with valid/ready on both sides.
module add_seq_ctrl
    import add_seq_ctrl_pkg::*;
#(
    parameter int NIBBLES = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start_valid,
    output logic                      start_ready,
    input  logic [NIBBLES*4-1:0]      a,
    input  logic [NIBBLES*4-1:0]      b,
    input  logic                      sub,
    output logic                      busy,
    output logic                      done_valid,
    input  logic                      done_ready,
    output logic [NIBBLES*4-1:0]      result,
    output logic                      cout,
    output logic                      overflow
);
    localparam int W  = NIBBLES * NIBBLE_W;
    localparam int IW = (clog2(NIBBLES) < 1) ? 1 : clog2(NIBBLES);
    localparam logic [IW-1:0] LAST_IDX = IW'(NIBBLES - 1);

    state_t state_q, state_d;

    logic [W-1:0]  a_q, b_q, res_q;
    logic [IW-1:0] idx;
    logic          carry, cout_q, ovf_q;
    logic          accept, step, last;

    logic [NIBBLE_W-1:0] nib_a, nib_b, nib_s;
    logic                nib_co;

    assign nib_a = a_q[idx*NIBBLE_W +: NIBBLE_W];
    assign nib_b = b_q[idx*NIBBLE_W +: NIBBLE_W];

    add4_ci u_add (
        .a  (nib_a),
        .b  (nib_b),
        .ci (carry),
        .s  (nib_s),
        .co (nib_co)
    );

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        step    = 1'b0;
        last    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start_valid) begin
                    accept  = 1'b1;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                step = 1'b1;
                if (idx == LAST_IDX) begin
                    last    = 1'b1;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (done_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    // Subtraction is A + ~B + 1: invert B once on accept and seed the carry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q    <= '0;
            b_q    <= '0;
            res_q  <= '0;
            idx    <= '0;
            carry  <= 1'b0;
            cout_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else if (accept) begin
            a_q   <= a;
            b_q   <= sub ? ~b : b;
            carry <= sub;
            idx   <= '0;
            res_q <= '0;
        end else if (step) begin
            res_q[idx*NIBBLE_W +: NIBBLE_W] <= nib_s;
            carry <= nib_co;
            idx   <= idx + 1'b1;
            if (last) begin
                cout_q <= nib_co;
                ovf_q  <= (a_q[W-1] == b_q[W-1]) && (nib_s[NIBBLE_W-1] != a_q[W-1]);
            end
        end
    end

    assign start_ready = (state_q == ST_IDLE);
    assign busy        = (state_q != ST_IDLE);
    assign done_valid  = (state_q == ST_DONE);
    assign result      = res_q;
    assign cout        = cout_q;
    assign overflow    = ovf_q;

endmodule

// File: doc/add_seq_ctrl.md
Name: add_seq_ctrl

Overview:
Nibble-serial multi-precision add/subtract controller. It sequences one 4-bit ripple adder slice (with carry-in) over NIBBLES cycles to produce a 4*NIBBLES-bit result. Operands are accepted and results returned through valid/ready handshakes. It sits between a requester (register file or test driver) and the shared 4-bit adder datapath, so wide arithmetic needs no wide adder.

Parameters:
NIBBLES, 4, number of 4-bit slices; operand width W = 4*NIBBLES; legal range 2..16.

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  asynchronous reset, active-high.
start_valid  input  1  requester presents an operation.
start_ready  output  1  controller can accept an operation.
a  input  W  operand A; sampled on accept.
b  input  W  operand B; sampled on accept.
sub  input  1  0 = A+B, 1 = A-B; sampled on accept.
busy  output  1  high in RUN or DONE.
done_valid  output  1  result available.
done_ready  input  1  consumer takes the result.
result  output  W  sum or difference.
cout  output  1  final carry out; for subtraction, 1 = no borrow.
overflow  output  1  two's-complement signed overflow.

Behaviour:
- One clock (clk). Reset is asynchronous and active-high (rst).
- On rst: FSM goes to IDLE, nibble index 0, carry 0, operand registers 0, result 0, cout 0, overflow 0, done_valid 0, busy 0, start_ready 1.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - start_ready = 1.
  - Accept occurs when start_valid is high on a clock edge.
  - On accept: latch a; latch b_eff = sub ? ~b : b; set carry = sub; set idx = 0; go to RUN.
- RUN:
  - start_ready = 0; busy = 1.
  - Each cycle: {c, s} = a[idx] + b_eff[idx] + carry, using 4-bit slices plus carry-in.
  - result[idx] <= s; carry <= c; idx <= idx + 1.
  - On the cycle that processes idx = NIBBLES-1:
    - cout <= c.
    - overflow <= (a[W-1] == b_eff[W-1]) && (s[3] != a[W-1]).
    - Go to DONE.
- DONE:
  - done_valid = 1; start_ready = 0.
  - result, cout and overflow hold stable until the handshake.
  - When done_ready is high on an edge: go to IDLE and deassert done_valid.
  - An operation cannot be accepted in the same cycle a result is released.
- Latency: accept on edge k gives done_valid high after edge k+NIBBLES. Throughput is at most one operation per NIBBLES+2 cycles with done_ready tied high.
- Registered outputs only; no combinational path from a, b or start_valid to any output.
- Inputs are ignored while busy. start_valid during RUN or DONE has no effect, and a, b, sub may change freely.
- result is cleared to 0 on accept. Partial nibbles are visible during RUN but are not valid until done_valid.
- Wrap-around: the sum is modulo 2^W; the carry is reported on cout.
- Reset mid-operation (RUN or DONE): immediate return to the reset state; the operation is discarded with no done_valid pulse.
- done_ready while not in DONE is ignored.

Decomposition:
- Shared package/header holds:
  - state encodings ST_IDLE = 2'd0, ST_RUN = 2'd1, ST_DONE = 2'd2;
  - NIBBLE_W = 4;
  - idx width function clog2(NIBBLES).
- One sub-module, add4_ci: a purely combinational 4-bit adder with carry-in, a[3:0], b[3:0], ci -> s[3:0], co. It is built from the existing 1-bit full-adder cell.
- The controller instantiates add4_ci exactly once and muxes its nibble inputs by idx.

Test Plan:
1. NIBBLES=4, a=0x1234, b=0x1111, sub=0, done_ready=1 -> done_valid exactly 4 cycles after accept; result=0x2345, cout=0, overflow=0; start_ready high again one cycle after the handshake.
2. a=0xFFFF, b=0x0001, sub=0 -> result=0x0000, cout=1, overflow=0. Then a=0x7FFF, b=0x0001 -> result=0x8000, cout=0, overflow=1.
3. a=0x0005, b=0x0007, sub=1 -> result=0xFFFE, cout=0 (borrow), overflow=0. Then a=0x8000, b=0x0001, sub=1 -> result=0x7FFF, cout=1, overflow=1.
4. Backpressure: hold done_ready=0 for 5 cycles in DONE while driving start_valid=1 with a=0xAAAA -> result, cout and overflow stable; start_ready=0; no second accept. Raise done_ready -> IDLE next cycle, then 0xAAAA is accepted.
5. Reset mid-operation: assert rst asynchronously 2 cycles into RUN -> all outputs immediately at reset values; after release, no done_valid until a new accept.
6. NIBBLES=2, a=0xFF, b=0xFF, sub=0 -> done_valid 2 cycles after accept; result=0xFE, cout=1, overflow=0.
